jk_bank_sequencer: RTL and testbench
====================================

JK_BANK_SEQUENCER -- requirements
Module: jk_bank_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, sets the number of JK flip-flops in the controlled bank (2..16).
REQ-002 clk_i  input  1  clock; all controller state SHALL update on the rising edge.
REQ-003 rst_i  input  1  reset; asynchronous and active-high.
REQ-004 cmd_valid_i  input  1  command request.
REQ-005 cmd_ready_o  output  1  controller can accept a command.
REQ-006 cmd_op_i  input  3  opcode: 000 NOP, 001 LOAD, 010 SET, 011 RESET, 100 TOGGLE, 101 COUNT_UP, 110 COUNT_DOWN, 111 CLEAR.
REQ-007 cmd_data_i  input  WIDTH  operand: the value for LOAD, the bit mask for SET/RESET/TOGGLE, the cycle count n for COUNT_UP/COUNT_DOWN; ignored for NOP/CLEAR.
REQ-008 q_i  input  WIDTH  Q feedback from the bank.
REQ-009 j_o, k_o  output  WIDTH each  J/K drive to the bank, which samples them on the falling edge of clk_i.
REQ-010 clear_n_o  output  1  active-low clear to the bank.
REQ-011 busy_o  output  1  command in progress.
REQ-012 done_o  output  1  one-cycle completion pulse.
REQ-013 mismatch_o  output  1  sticky self-check error flag (see Configuration).

Function
REQ-014 The FSM SHALL have the states IDLE, APPLY, COUNT and DONE; cmd_ready_o SHALL be 1 only in IDLE, and busy_o SHALL be 1 in APPLY, COUNT and DONE.
REQ-015 A command is accepted on the rising edge where cmd_valid_i and cmd_ready_o are both 1; the opcode and operand SHALL be registered, and the inputs are ignored at every other time.
REQ-016 From IDLE, an accepted COUNT_UP or COUNT_DOWN with n>0 SHALL go to COUNT, with n=0 SHALL go directly to DONE, and any other accepted opcode SHALL go to APPLY.
REQ-017 APPLY SHALL last exactly one cycle and then go to DONE.
REQ-018 Drive in APPLY, per bit i:
- LOAD: j=d[i], k=~d[i].
- SET: j=m[i], k=0.
- RESET: j=0, k=m[i].
- TOGGLE: j=k=m[i].
- NOP: j=k=0.
- CLEAR: j=k=0 and clear_n_o=0 for the whole cycle.
REQ-019 COUNT SHALL last exactly n cycles, using a WIDTH-bit down-counter loaded with n, and then go to DONE.
REQ-020 In each COUNT cycle, j_o=k_o=T, recomputed combinationally from q_i:
- COUNT_UP: T[0]=1 and T[i]=&q_i[i-1:0].
- COUNT_DOWN: T[0]=1 and T[i]=&~q_i[i-1:0].
REQ-021 Counting SHALL wrap modulo 2^WIDTH: up from all-ones gives 0, and down from 0 gives all-ones.
REQ-022 In DONE, done_o=1 and j_o=k_o=0 for exactly one cycle, then the FSM SHALL return to IDLE; a back-to-back command is accepted at the earliest on the edge after DONE.
REQ-023 Outside APPLY and COUNT, j_o=k_o=0, and clear_n_o=1 except as given in REQ-018 and REQ-026.
REQ-024 Latency: for an accepted single-step command, done_o SHALL be high in the second cycle after acceptance; for COUNT with n>0, done_o SHALL be high n+1 cycles after acceptance.

Reset
REQ-025 While rst_i=1, the FSM SHALL be in IDLE with cmd_ready_o=0, busy_o=0, done_o=0, j_o=k_o=0, mismatch_o=0 and the internal counter and expected value at 0.
REQ-026 clear_n_o SHALL be 0 combinationally while rst_i=1, so that the bank clears asynchronously.
REQ-027 Reset asserted mid-command SHALL abort the command without a done_o pulse; cmd_ready_o SHALL rise on the first rising edge after rst_i deasserts.

Configuration
REQ-028 Macro JK_BANK_SEQUENCER_SELFCHECK_EN: when defined, the block SHALL keep an expected bank value E, with E=0 at reset.
REQ-029 With the macro defined, E SHALL be updated per command:
- LOAD: E=d.
- SET: E|=m.
- RESET: E&=~m.
- TOGGLE: E^=m.
- COUNT_UP: E+=n.
- COUNT_DOWN: E-=n.
- CLEAR: E=0.
- NOP: unchanged.
All arithmetic is modulo 2^WIDTH.
REQ-030 With the macro defined, in DONE, if q_i≠E, mismatch_o SHALL be set and SHALL stay set until reset.
REQ-031 Without the macro, mismatch_o SHALL be tied to 0 and no E register SHALL exist; the port list is identical in both builds.

Verification
REQ-032 Reset release, then LOAD 4'b1010 -> j_o=1010, k_o=0101 for one cycle, done_o the cycle after, q_i=1010.
REQ-033 From q=1010: SET 0101, then RESET 0011, then TOGGLE 1111 -> q=1111, then 1100, then 0011; mismatch_o=0.
REQ-034 LOAD 1110, then COUNT_UP n=3 -> q sequence 1111, 0000, 0001 (wrap); done_o 4 cycles after acceptance.
REQ-035 LOAD 0001, then COUNT_DOWN n=2 -> q 0000 then 1111; COUNT_UP n=0 -> done_o 1 cycle after acceptance with no J/K activity.
REQ-036 rst_i pulsed in mid COUNT_UP n=8 -> clear_n_o=0 immediately, no done_o, q=0000, cmd_ready_o=1 on the edge after release.
REQ-037 With JK_BANK_SEQUENCER_SELFCHECK_EN defined, force q_i to differ from E at DONE -> mismatch_o=1 and it stays 1 until reset.

Source files
------------

// File: rtl/jk_bank_sequencer.sv
// Command sequencer driving a bank of WIDTH JK flip-flops (load/set/reset/toggle/count/clear).
// Optional expected-value self-check is enabled by defining JK_BANK_SEQUENCER_SELFCHECK_EN.
module jk_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             clear_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             mismatch_o
);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_RESET  = 3'b011;
    localparam logic [2:0] OP_TOGGLE = 3'b100;
    localparam logic [2:0] OP_CNT_UP = 3'b101;
    localparam logic [2:0] OP_CNT_DN = 3'b110;
    localparam logic [2:0] OP_CLEAR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic             ready_q;
    logic             done_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] cnt_q;
    logic             accept;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] j_drive;
    logic [WIDTH-1:0] k_drive;

    assign accept = (state_q == IDLE) && cmd_valid_i && ready_q;

    // Counter toggle masks: bit i flips when all lower bits are 1 (up) or 0 (down).
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_toggle
            if (gi == 0) begin : g_lsb
                assign t_up[gi] = 1'b1;
                assign t_dn[gi] = 1'b1;
            end else begin : g_upper
                assign t_up[gi] = &q_i[gi-1:0];
                assign t_dn[gi] = &(~q_i[gi-1:0]);
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (accept) begin
                        op_q    <= cmd_op_i;
                        data_q  <= cmd_data_i;
                        ready_q <= 1'b0;
                        if (cmd_op_i == OP_CNT_UP || cmd_op_i == OP_CNT_DN) begin
                            if (cmd_data_i == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= COUNT;
                                cnt_q   <= cmd_data_i;
                            end
                        end else begin
                            state_q <= APPLY;
                        end
                    end
                end
                APPLY: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                COUNT: begin
                    cnt_q <= cnt_q - WIDTH'(1);
                    if (cnt_q == WIDTH'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        j_drive = '0;
        k_drive = '0;
        case (state_q)
            APPLY: begin
                case (op_q)
                    OP_LOAD: begin
                        j_drive = data_q;
                        k_drive = ~data_q;
                    end
                    OP_SET:    j_drive = data_q;
                    OP_RESET:  k_drive = data_q;
                    OP_TOGGLE: begin
                        j_drive = data_q;
                        k_drive = data_q;
                    end
                    default: begin
                        j_drive = '0;
                        k_drive = '0;
                    end
                endcase
            end
            COUNT: begin
                j_drive = (op_q == OP_CNT_UP) ? t_up : t_dn;
                k_drive = (op_q == OP_CNT_UP) ? t_up : t_dn;
            end
            default: begin
                j_drive = '0;
                k_drive = '0;
            end
        endcase
    end

    assign j_o         = j_drive;
    assign k_o         = k_drive;
    assign clear_n_o   = ~rst_i && !(state_q == APPLY && op_q == OP_CLEAR);
    assign cmd_ready_o = ready_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

`ifdef JK_BANK_SEQUENCER_SELFCHECK_EN
    logic [WIDTH-1:0] e_q;
    logic [WIDTH-1:0] e_d;
    logic             mismatch_q;

    // Expected value is advanced at acceptance; the bank must match it by DONE.
    always_comb begin
        e_d = e_q;
        case (cmd_op_i)
            OP_LOAD:   e_d = cmd_data_i;
            OP_SET:    e_d = e_q | cmd_data_i;
            OP_RESET:  e_d = e_q & ~cmd_data_i;
            OP_TOGGLE: e_d = e_q ^ cmd_data_i;
            OP_CNT_UP: e_d = e_q + cmd_data_i;
            OP_CNT_DN: e_d = e_q - cmd_data_i;
            OP_CLEAR:  e_d = '0;
            default:   e_d = e_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e_q        <= '0;
            mismatch_q <= 1'b0;
        end else begin
            if (accept) begin
                e_q <= e_d;
            end
            if (state_q == DONE && q_i != e_q) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    assign mismatch_o = mismatch_q;
`else
    assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Randomized bench: a JK bank model closes the loop, an arithmetic model predicts the bank value.
module tb_jk_bank_sequencer;

    localparam int W = 4;
    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, SET = 3'd2, RST = 3'd3,
                           TOG = 3'd4, UP = 3'd5, DN = 3'd6, CLR = 3'd7;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         cmd_valid_i = 1'b0;
    logic         cmd_ready_o;
    logic [2:0]   cmd_op_i = 3'd0;
    logic [W-1:0] cmd_data_i = '0;
    logic [W-1:0] q_i;
    logic [W-1:0] j_o, k_o;
    logic         clear_n_o, busy_o, done_o, mismatch_o;

    logic [W-1:0] bank = '0;
    logic [W-1:0] force_mask = '0;
    logic [W-1:0] e_model = '0;
    logic         mm_exp = 1'b0;
    int           n_cmp = 0;
    int           n_bad = 0;

    jk_bank_sequencer #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i), .q_i(q_i), .j_o(j_o), .k_o(k_o),
        .clear_n_o(clear_n_o), .busy_o(busy_o), .done_o(done_o), .mismatch_o(mismatch_o)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank: samples on the falling edge, clears asynchronously.
    always @(negedge clk or negedge clear_n_o) begin
        if (!clear_n_o) bank <= '0;
        else            bank <= (j_o & ~bank) | (~k_o & bank);
    end
    assign q_i = bank ^ force_mask;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] e_next(input logic [2:0] op, input logic [W-1:0] d,
                                            input logic [W-1:0] e);
        case (op)
            LOAD:    return d;
            SET:     return e | d;
            RST:     return e & ~d;
            TOG:     return e ^ d;
            UP:      return e + d;
            DN:      return e - d;
            CLR:     return '0;
            default: return e;
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d);
        int guard = 0;
        int lat;
        logic [W-1:0] start, v, ej, ek;
        logic eclr;
        while (!cmd_ready_o && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_wait", 32'(cmd_ready_o), 32'd1);
        if (!cmd_ready_o) return;
        start = e_model;
        if (op == UP || op == DN) lat = (d == '0) ? 1 : int'(d) + 1;
        else                      lat = 2;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_data_i  = d;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 3'($urandom);
        cmd_data_i  = W'($urandom);
        e_model     = e_next(op, d, start);
        for (int c = 1; c <= lat; c++) begin
            ej = '0; ek = '0; eclr = 1'b1;
            if (c < lat) begin
                if (op == UP || op == DN) begin
                    v  = (op == UP) ? start + W'(c - 1) : start - W'(c - 1);
                    ej = (op == UP) ? (v ^ (v + W'(1))) : (v ^ (v - W'(1)));
                    ek = ej;
                    check("count_q", 32'(bank), 32'(v));
                end else begin
                    case (op)
                        LOAD: begin ej = d; ek = ~d; end
                        SET:  ej = d;
                        RST:  ek = d;
                        TOG:  begin ej = d; ek = d; end
                        CLR:  eclr = 1'b0;
                        default: ;
                    endcase
                end
            end else begin
                check("done_q", 32'(bank), 32'(e_model));
            end
            check("done", 32'(done_o), 32'(c == lat));
            check("busy", 32'(busy_o), 32'd1);
            check("ready_busy", 32'(cmd_ready_o), 32'd0);
            check("j", 32'(j_o), 32'(ej));
            check("k", 32'(k_o), 32'(ek));
            check("clear_n", 32'(clear_n_o), 32'(eclr));
            if (c < lat) begin
                @(posedge clk); #1;
            end
        end
`ifdef JK_BANK_SEQUENCER_SELFCHECK_EN
        if (q_i !== e_model) mm_exp = 1'b1;
`endif
        @(posedge clk); #1;
        check("done_after", 32'(done_o), 32'd0);
        check("ready_after", 32'(cmd_ready_o), 32'd1);
        check("busy_after", 32'(busy_o), 32'd0);
        check("jk_idle", 32'({j_o, k_o}), 32'd0);
        check("mismatch", 32'(mismatch_o), 32'(mm_exp));
        $display("cmd op=%0d data=%h lat=%0d q=%h expect=%h", op, d, lat, bank, e_model);
    endtask

    initial begin
        #3;
        check("rst_ready", 32'(cmd_ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_jk", 32'({j_o, k_o}), 32'd0);
        check("rst_clear_n", 32'(clear_n_o), 32'd0);
        check("rst_mismatch", 32'(mismatch_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_ready", 32'(cmd_ready_o), 32'd0);
        #2 rst_i = 1'b0;
        #1;
        check("rel_clear_n", 32'(clear_n_o), 32'd1);
        check("rel_ready_pre", 32'(cmd_ready_o), 32'd0);
        @(posedge clk); #1;
        check("rel_ready", 32'(cmd_ready_o), 32'd1);

        run_cmd(LOAD, 4'b1010);
        run_cmd(SET,  4'b0101);
        run_cmd(RST,  4'b0011);
        run_cmd(TOG,  4'b1111);
        check("seq_q", 32'(bank), 32'(4'b0011));
        run_cmd(LOAD, 4'b1110);
        run_cmd(UP,   4'd3);
        check("wrap_up", 32'(bank), 32'(4'b0001));
        run_cmd(LOAD, 4'b0001);
        run_cmd(DN,   4'd2);
        check("wrap_dn", 32'(bank), 32'(4'b1111));
        run_cmd(UP,   4'd0);
        run_cmd(CLR,  4'b1011);
        run_cmd(NOP,  4'b0110);

        for (int t = 0; t < 40; t++) begin
            run_cmd(3'($urandom_range(0, 7)), W'($urandom));
        end

        force_mask = 4'b0001;
        run_cmd(NOP, 4'b0000);
        force_mask = '0;
        run_cmd(LOAD, 4'b0101);

        // Reset in the middle of an eight-cycle count.
        run_cmd(LOAD, 4'b0011);
        cmd_valid_i = 1'b1;
        cmd_op_i    = UP;
        cmd_data_i  = 4'd8;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_i = 1'b1;
        #1;
        e_model = '0;
        mm_exp  = 1'b0;
        check("mid_clear_n", 32'(clear_n_o), 32'd0);
        check("mid_bank", 32'(bank), 32'd0);
        check("mid_busy", 32'(busy_o), 32'd0);
        check("mid_ready", 32'(cmd_ready_o), 32'd0);
        check("mid_mismatch", 32'(mismatch_o), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("mid_no_done", 32'(done_o), 32'd0);
            check("mid_jk", 32'({j_o, k_o}), 32'd0);
        end
        #2 rst_i = 1'b0;
        #1;
        check("mid_ready_pre", 32'(cmd_ready_o), 32'd0);
        @(posedge clk); #1;
        check("mid_ready_post", 32'(cmd_ready_o), 32'd1);
        check("mid_done_post", 32'(done_o), 32'd0);
        run_cmd(UP, 4'd5);
        run_cmd(DN, 4'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
